btn_debounce: RTL and testbench
===============================

// Module: btn_debounce
// PURPOSE
//  Front end for the push buttons BTN_1..BTN_3, feeding button_ctrl.
//  - Synchronises each raw pin to CLK and debounces it.
//  - Emits a clean level plus one-cycle press and release strobes per button.
//  - button_ctrl steps main/sub mode, PLL address and CLR_SEQ from the press strobes only.
// PARAMETERS
//  N_BTN    3        number of buttons
//  ACT_LOW  1        1: pin low = pressed; 0: pin high = pressed
//  CNT_W    20       debounce/repeat counter width
//  DEB_CNT  500000   stable cycles required to accept a change (10 ms at 50 MHz); >=2
//  REP_DLY  25000000 held cycles from press strobe to first repeat strobe (macro only)
//  REP_PER  5000000  cycles between later repeat strobes (macro only)
// PORTS
//  CLK      in  1      system clock (board CLK)
//  RSTX     in  1      asynchronous active-low reset
//  BTN_IN   in  N_BTN  raw button pins, asynchronous to CLK
//  BTN_LVL  out N_BTN  debounced level, 1 = pressed
//  BTN_PRS  out N_BTN  1-cycle strobe on accepted press
//  BTN_REL  out N_BTN  1-cycle strobe on accepted release
//  BTN_REP  out N_BTN  1-cycle auto-repeat strobe while held
// BEHAVIOUR
//  - Reset (RSTX=0):
//    - all sync flops hold the released value; all counters clear.
//    - BTN_LVL, BTN_PRS, BTN_REL and BTN_REP are all 0.
//  - Sync: two flops per bit; the polarity flip per ACT_LOW is applied after the 2nd flop, giving s[i].
//  - Per-button counter cnt[i] (CNT_W bits):
//    - s[i]==BTN_LVL[i]: cnt clears next edge.
//    - s[i]!=BTN_LVL[i] and cnt<DEB_CNT-1: cnt increments.
//    - s[i]!=BTN_LVL[i] and cnt==DEB_CNT-1: BTN_LVL[i] toggles and cnt clears.
//  - Strobes: BTN_PRS[i]=1 on the edge BTN_LVL[i] goes 0->1; BTN_REL[i]=1 on the edge it goes 1->0.
//    - Both are registered and high for exactly 1 cycle.
//    - Never both high for the same button.
//  - Latency: a clean pin change appears on BTN_LVL DEB_CNT+2 edges after the first edge that samples it.
//  - Chatter: any return of s[i] to BTN_LVL[i] before terminal count restarts the count from 0. No strobe.
//  - Buttons are fully independent; any combination of strobes may assert in the same cycle.
//  - Counter saturates logically at DEB_CNT-1 and never wraps.
//  - Reset mid-count discards the partial count.
//    - A button held through reset release yields BTN_PRS DEB_CNT+2 cycles after RSTX rises.
// CONFIGURATION
//  Macro BTN_AUTO_REPEAT_EN
//  - Defined: per-button repeat counter rcnt[i].
//    - Clears on BTN_PRS[i] and whenever BTN_LVL[i]=0.
//    - BTN_REP[i] pulses REP_DLY cycles after BTN_PRS[i], then every REP_PER cycles while BTN_LVL[i]=1.
//    - The press strobe itself is never duplicated on BTN_REP.
//  - Undefined: BTN_REP is tied to 0; no repeat logic is synthesised. Port list is unchanged.
// TESTING  (DEB_CNT=8, REP_DLY=20, REP_PER=10, ACT_LOW=1, N_BTN=3)
//  - Reset, BTN_IN=3'b111 for 50 cycles -> all outputs 0 throughout, no strobes.
//  - BTN_IN[0] 1->0 clean -> BTN_LVL[0]=1 and 1-cycle BTN_PRS[0] exactly 10 edges later.
//    - Pin back to 1 -> 1-cycle BTN_REL[0] 10 edges later.
//  - BTN_IN[1] toggled every 5 cycles for 40 cycles, then low for 7 cycles, then high -> no strobe, BTN_LVL[1] stays 0.
//  - BTN_IN 3'b111->3'b000 in one cycle -> BTN_PRS=3'b111 in a single cycle, 10 edges later.
//  - BTN_IN[2] low; RSTX pulsed low when cnt=5 -> outputs 0 during reset.
//    - Pin still low -> BTN_PRS[2] 10 edges after RSTX rises.
//  - Macro defined, BTN_IN[0] held low 100 cycles past BTN_PRS[0] -> BTN_REP[0] at +20,+30,...,+100 (9 strobes).
//    - Macro undefined -> BTN_REP stays 0.

Source files
------------

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
//
// Front end for the board push buttons. Every raw pin is brought into the CLK
// domain through a two-flop synchroniser, normalised so that 1 = pressed, and
// debounced by a per-button stability counter. Outputs are a clean level plus
// one-cycle press / release strobes per button. An optional auto-repeat strobe
// is produced while a button stays held.
//
// Build option:
//   BTN_AUTO_REPEAT_EN  when defined, BTN_REP pulses REP_DLY cycles after a
//                       press strobe and every REP_PER cycles after that while
//                       the button stays held. When undefined, BTN_REP is
//                       tied to 0 and no repeat logic exists. The port list is
//                       the same in both builds.
//
// Parameters:
//   N_BTN    number of buttons
//   ACT_LOW  1: pin low = pressed, 0: pin high = pressed
//   CNT_W    debounce counter width (must hold DEB_CNT-1)
//   DEB_CNT  stable cycles needed to accept a change (>= 2)
//   REP_DLY  cycles from press strobe to first repeat strobe
//   REP_PER  cycles between later repeat strobes
//
// Ports:
//   CLK      in   system clock
//   RSTX     in   asynchronous active-low reset
//   BTN_IN   in   [N_BTN] raw button pins, asynchronous to CLK
//   BTN_LVL  out  [N_BTN] debounced level, 1 = pressed
//   BTN_PRS  out  [N_BTN] one-cycle strobe on accepted press
//   BTN_REL  out  [N_BTN] one-cycle strobe on accepted release
//   BTN_REP  out  [N_BTN] one-cycle auto-repeat strobe while held
// ---------------------------------------------------------------------------
module btn_debounce #(
    parameter int N_BTN   = 3,
    parameter int ACT_LOW = 1,
    parameter int CNT_W   = 20,
    parameter int DEB_CNT = 500000,
    parameter int REP_DLY = 25000000,
    parameter int REP_PER = 5000000
) (
    input  logic             CLK,
    input  logic             RSTX,
    input  logic [N_BTN-1:0] BTN_IN,
    output logic [N_BTN-1:0] BTN_LVL,
    output logic [N_BTN-1:0] BTN_PRS,
    output logic [N_BTN-1:0] BTN_REL,
    output logic [N_BTN-1:0] BTN_REP
);

    // Terminal count of the debounce counter: the change is accepted on the
    // edge that sees the counter already sitting here.
    localparam logic [CNT_W-1:0] DEB_TERM = CNT_W'(DEB_CNT - 1);

    // Raw pin value of a released button; the synchroniser resets to it so a
    // button held through reset is seen as a fresh press afterwards.
    localparam logic [N_BTN-1:0] PIN_IDLE = (ACT_LOW != 0) ? {N_BTN{1'b1}} : {N_BTN{1'b0}};

    // Elaboration-time sanity check of the timing parameters.
    if ((N_BTN < 1) || (CNT_W < 1) || (DEB_CNT < 2) || (REP_DLY < 1) || (REP_PER < 1) ||
        (longint'(DEB_CNT - 1) >= (longint'(1) << CNT_W))) begin : g_bad_cfg
        $error("btn_debounce: invalid parameter set");
    end

`ifdef BTN_AUTO_REPEAT_EN
    // The repeat counter is sized from the repeat timings themselves, since
    // the hold-off before the first repeat is far longer than a debounce.
    localparam int REP_MAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DLY_TERM = REP_W'(REP_DLY - 1);
    localparam logic [REP_W-1:0] REP_PER_TERM = REP_W'(REP_PER - 1);
`endif

    // -----------------------------------------------------------------------
    // Two-flop synchroniser, polarity normalised after the second flop
    // -----------------------------------------------------------------------
    logic [N_BTN-1:0] sync1_reg;
    logic [N_BTN-1:0] sync2_reg;
    logic [N_BTN-1:0] s;

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            sync1_reg <= PIN_IDLE;
            sync2_reg <= PIN_IDLE;
        end else begin
            sync1_reg <= BTN_IN;
            sync2_reg <= sync1_reg;
        end
    end

    assign s = (ACT_LOW != 0) ? ~sync2_reg : sync2_reg;

    // -----------------------------------------------------------------------
    // Per-button debounce, strobes and optional auto-repeat
    // -----------------------------------------------------------------------
    genvar gi;
    for (gi = 0; gi < N_BTN; gi++) begin : g_btn
        logic [CNT_W-1:0] cnt_reg;
        logic [CNT_W-1:0] cnt_next;
        logic             lvl_reg;
        logic             lvl_next;
        logic             prs_reg;
        logic             prs_next;
        logic             rel_reg;
        logic             rel_next;

        // The counter only runs while the synchronised pin disagrees with the
        // accepted level; any agreement (chatter) drops it back to zero. It
        // clears on acceptance, so it never passes DEB_TERM.
        always_comb begin
            cnt_next = '0;
            lvl_next = lvl_reg;
            prs_next = 1'b0;
            rel_next = 1'b0;
            if (s[gi] != lvl_reg) begin
                if (cnt_reg == DEB_TERM) begin
                    lvl_next = ~lvl_reg;
                    prs_next = ~lvl_reg;
                    rel_next = lvl_reg;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
        end

        always_ff @(posedge CLK or negedge RSTX) begin
            if (!RSTX) begin
                cnt_reg <= '0;
                lvl_reg <= 1'b0;
                prs_reg <= 1'b0;
                rel_reg <= 1'b0;
            end else begin
                cnt_reg <= cnt_next;
                lvl_reg <= lvl_next;
                prs_reg <= prs_next;
                rel_reg <= rel_next;
            end
        end

        assign BTN_LVL[gi] = lvl_reg;
        assign BTN_PRS[gi] = prs_reg;
        assign BTN_REL[gi] = rel_reg;

`ifdef BTN_AUTO_REPEAT_EN
        logic [REP_W-1:0] rcnt_reg;
        logic [REP_W-1:0] rcnt_next;
        logic             first_reg;
        logic             first_next;
        logic             rep_reg;
        logic             rep_next;

        // rcnt restarts on the press edge itself (lvl still 0) and stays
        // clear while released or on the release edge, so no repeat can share
        // a cycle with either strobe. first_reg selects the long initial
        // hold-off versus the shorter repeat period.
        always_comb begin
            rcnt_next  = rcnt_reg;
            first_next = first_reg;
            rep_next   = 1'b0;
            if (!(lvl_reg && lvl_next)) begin
                rcnt_next  = '0;
                first_next = 1'b1;
            end else if (rcnt_reg == (first_reg ? REP_DLY_TERM : REP_PER_TERM)) begin
                rcnt_next  = '0;
                first_next = 1'b0;
                rep_next   = 1'b1;
            end else begin
                rcnt_next = rcnt_reg + 1'b1;
            end
        end

        always_ff @(posedge CLK or negedge RSTX) begin
            if (!RSTX) begin
                rcnt_reg  <= '0;
                first_reg <= 1'b1;
                rep_reg   <= 1'b0;
            end else begin
                rcnt_reg  <= rcnt_next;
                first_reg <= first_next;
                rep_reg   <= rep_next;
            end
        end

        assign BTN_REP[gi] = rep_reg;
`else
        assign BTN_REP[gi] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_btn_debounce.sv
// ---------------------------------------------------------------------------
// tb_btn_debounce
//
// Directed bench for btn_debounce with DEB_CNT=8, REP_DLY=20, REP_PER=10,
// ACT_LOW=1, N_BTN=3. Stimulus pushes the expected strobe events (cycle and
// full output vector) into a queue; a monitor pops one entry for every cycle
// in which the DUT shows any strobe and compares. Level/quiet checks are made
// directly by the stimulus process at chosen points.
// ---------------------------------------------------------------------------
module tb_btn_debounce;

    localparam int DEB = 8;
    localparam int LAT = DEB + 2;

    logic       clk  = 1'b0;
    logic       rstx = 1'b0;
    logic [2:0] btn_in = 3'b111;
    logic [2:0] lvl;
    logic [2:0] prs;
    logic [2:0] rel;
    logic [2:0] rep;

    btn_debounce #(
        .N_BTN  (3),
        .ACT_LOW(1),
        .CNT_W  (20),
        .DEB_CNT(DEB),
        .REP_DLY(20),
        .REP_PER(10)
    ) dut (
        .CLK    (clk),
        .RSTX   (rstx),
        .BTN_IN (btn_in),
        .BTN_LVL(lvl),
        .BTN_PRS(prs),
        .BTN_REL(rel),
        .BTN_REP(rep)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far; read on falling edges.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [2:0] lvl;
        logic [2:0] prs;
        logic [2:0] rel;
        logic [2:0] rep;
    } ev_t;

    ev_t exp_q[$];
    int  vectors     = 0;
    int  miscompares = 0;

    task automatic expect_ev(input int c, input logic [2:0] l, input logic [2:0] p,
                             input logic [2:0] r, input logic [2:0] rp);
        ev_t e;
        e.cyc = c;
        e.lvl = l;
        e.prs = p;
        e.rel = r;
        e.rep = rp;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Compare the whole output vector {lvl,prs,rel,rep} against a constant.
    task automatic check_out(input string name, input logic [11:0] exp_v, input bit loud);
        vectors++;
        if ({lvl, prs, rel, rep} !== exp_v) begin
            miscompares++;
            $display("FAIL %s cyc=%0d lvl/prs/rel/rep got=%b required=%b",
                     name, cyc, {lvl, prs, rel, rep}, exp_v);
        end else if (loud) begin
            $display("ok   %s cyc=%0d lvl/prs/rel/rep=%b", name, cyc, {lvl, prs, rel, rep});
        end
    endtask

    // Scoreboard monitor: every strobe cycle must match the next expectation.
    always @(negedge clk) begin
        if ((prs | rel | rep) !== 3'b000) begin
            ev_t e;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_strobe cyc=%0d got lvl=%b prs=%b rel=%b rep=%b required no strobe",
                         cyc, lvl, prs, rel, rep);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.lvl !== lvl || e.prs !== prs || e.rel !== rel || e.rep !== rep) begin
                    miscompares++;
                    $display("FAIL strobe_event got cyc=%0d lvl=%b prs=%b rel=%b rep=%b required cyc=%0d lvl=%b prs=%b rel=%b rep=%b",
                             cyc, lvl, prs, rel, rep, e.cyc, e.lvl, e.prs, e.rel, e.rep);
                end else begin
                    $display("ok   strobe_event cyc=%0d lvl=%b prs=%b rel=%b rep=%b",
                             cyc, lvl, prs, rel, rep);
                end
            end
        end
    end

    initial begin
        int c;

        // Reset state
        tick(3);
        check_out("reset_state", 12'b0, 1'b1);
        rstx = 1'b1;

        // All released for 50 cycles: nothing may move
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check_out("idle", 12'b0, 1'b0);
        end
        check_out("idle_end", 12'b0, 1'b1);

        // Clean press / release of button 0
        btn_in[0] = 1'b0;
        c = cyc;
        expect_ev(c + LAT, 3'b001, 3'b001, 3'b000, 3'b000);
        tick(15);
        check_out("held0", {3'b001, 9'b0}, 1'b1);
        btn_in[0] = 1'b1;
        c = cyc;
        expect_ev(c + LAT, 3'b000, 3'b000, 3'b001, 3'b000);
        tick(20);
        check_out("released0", 12'b0, 1'b1);

        // Chatter on button 1: 5-cycle toggles, then 7 low cycles (one short)
        for (int k = 0; k < 8; k++) begin
            btn_in[1] = k[0];
            for (int j = 0; j < 5; j++) begin
                @(negedge clk);
                check_out("chatter", 12'b0, 1'b0);
            end
        end
        btn_in[1] = 1'b0;
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            check_out("chatter_7low", 12'b0, 1'b0);
        end
        btn_in[1] = 1'b1;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            check_out("chatter_settle", 12'b0, 1'b0);
        end
        check_out("chatter_end", 12'b0, 1'b1);

        // All three pressed together, then released together
        btn_in = 3'b000;
        c = cyc;
        expect_ev(c + LAT, 3'b111, 3'b111, 3'b000, 3'b000);
        tick(15);
        check_out("held_all", {3'b111, 9'b0}, 1'b1);
        btn_in = 3'b111;
        c = cyc;
        expect_ev(c + LAT, 3'b000, 3'b000, 3'b111, 3'b000);
        tick(20);
        check_out("released_all", 12'b0, 1'b1);

        // Button 2 pressed, reset pulsed when its counter has reached 5
        btn_in[2] = 1'b0;
        tick(7);
        rstx = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check_out("in_reset", 12'b0, 1'b1);
        end
        rstx = 1'b1;
        c = cyc;
        expect_ev(c + LAT, 3'b100, 3'b100, 3'b000, 3'b000);
        tick(9);
        check_out("post_reset_wait", 12'b0, 1'b1);
        tick(6);
        check_out("held2", {3'b100, 9'b0}, 1'b1);
        btn_in[2] = 1'b1;
        c = cyc;
        expect_ev(c + LAT, 3'b000, 3'b000, 3'b100, 3'b000);
        tick(20);

        // Long hold on button 0: repeats at +20,+30,...,+100 after the press
        btn_in[0] = 1'b0;
        c = cyc;
        expect_ev(c + LAT, 3'b001, 3'b001, 3'b000, 3'b000);
`ifdef BTN_AUTO_REPEAT_EN
        for (int k = 0; k < 9; k++) begin
            expect_ev(c + LAT + 20 + 10 * k, 3'b001, 3'b000, 3'b000, 3'b001);
        end
`endif
        tick(101);
        btn_in[0] = 1'b1;
        expect_ev(c + 101 + LAT, 3'b000, 3'b000, 3'b001, 3'b000);
        tick(20);
        check_out("final_idle", 12'b0, 1'b1);

        // Any expectation left over is a strobe that never came
        while (exp_q.size() != 0) begin
            ev_t e;
            e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_strobe got none required cyc=%0d lvl=%b prs=%b rel=%b rep=%b",
                     e.cyc, e.lvl, e.prs, e.rel, e.rep);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Time bound on the whole run
    initial begin
        #100000;
        miscompares++;
        $display("FAIL watchdog got timeout required completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

endmodule
